// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control unit for the RV32I multicycle processor. It sequences every
// instruction through a fixed five-state FSM and decodes the current
// instruction word combinationally into the datapath controls.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset, aborts the current instruction
//   instr     current instruction word, held stable from IF through WB
//   Zero      ALU zero flag from the datapath
//   PCSrc     1 = PC + branch offset, 0 = PC + 4 (consumed in WB)
//   ALUSrc    1 = immediate operand, 0 = rs2
//   ALUCtrl   ALU operation code
//   RegWrite  register-file write enable (WB only)
//   MemToReg  1 = write back load data, 0 = ALU result
//   loadPC    PC update enable (WB only)
//   MemRead   data-memory read strobe (MEM only)
//   MemWrite  data-memory write strobe (MEM only)
//   illegal   current instruction is unsupported
//   state     FSM state, for debug
//
// state | meaning
// ------+------------------------------------------------
// IF  0 | instruction fetch
// ID  1 | decode / register read
// EX  2 | execute
// MEM 3 | data-memory access (MemRead / MemWrite)
// WB  4 | write back (RegWrite) and PC update (loadPC)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int ALUCTRL_W = 4,
    parameter int STATE_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 Zero,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic [ALUCTRL_W-1:0] ALUCtrl,
    output logic                 RegWrite,
    output logic                 MemToReg,
    output logic                 loadPC,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_XOR  = 4'b1100;

    logic [2:0] state_q;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f7_base;
    logic       f7_alt;
    logic       legal;
    logic [3:0] alu_code;
    logic       is_r, is_i, is_lw, is_sw, is_br;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign f7_base = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            case (state_q)
                S_IF:    state_q <= S_ID;
                S_ID:    state_q <= S_EX;
                S_EX:    state_q <= S_MEM;
                S_MEM:   state_q <= S_WB;
                default: state_q <= S_IF;   // WB and unused codes 5-7
            endcase
        end
    end

    always_comb begin
        legal    = 1'b0;
        alu_code = ALU_ADD;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin legal = f7_base | f7_alt; alu_code = f7_alt ? ALU_SUB : ALU_ADD; end
                    3'b001: begin legal = f7_base; alu_code = ALU_SLL;  end
                    3'b010: begin legal = f7_base; alu_code = ALU_SLT;  end
                    3'b011: begin legal = f7_base; alu_code = ALU_SLTU; end
                    3'b100: begin legal = f7_base; alu_code = ALU_XOR;  end
                    3'b101: begin legal = f7_base | f7_alt; alu_code = f7_alt ? ALU_SRA : ALU_SRL; end
                    3'b110: begin legal = f7_base; alu_code = ALU_OR;   end
                    default: begin legal = f7_base; alu_code = ALU_AND; end
                endcase
            end
            OP_I: begin
                // Only the shifts constrain the upper bits; elsewhere they are immediate.
                case (funct3)
                    3'b000: begin legal = 1'b1; alu_code = ALU_ADD;  end
                    3'b001: begin legal = f7_base; alu_code = ALU_SLL; end
                    3'b010: begin legal = 1'b1; alu_code = ALU_SLT;  end
                    3'b011: begin legal = 1'b1; alu_code = ALU_SLTU; end
                    3'b100: begin legal = 1'b1; alu_code = ALU_XOR;  end
                    3'b101: begin legal = f7_base | f7_alt; alu_code = f7_alt ? ALU_SRA : ALU_SRL; end
                    3'b110: begin legal = 1'b1; alu_code = ALU_OR;   end
                    default: begin legal = 1'b1; alu_code = ALU_AND; end
                endcase
            end
            OP_LOAD:   legal = (funct3 == 3'b010);
            OP_STORE:  legal = (funct3 == 3'b010);
            OP_BRANCH: begin
                legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
                alu_code = ALU_SUB;
            end
            default:   legal = 1'b0;
        endcase
        // Unsupported encodings fall back to a harmless ADD.
        if (!legal) begin
            alu_code = ALU_ADD;
        end
    end

    assign is_r  = legal && (opcode == OP_R);
    assign is_i  = legal && (opcode == OP_I);
    assign is_lw = legal && (opcode == OP_LOAD);
    assign is_sw = legal && (opcode == OP_STORE);
    assign is_br = legal && (opcode == OP_BRANCH);

    assign illegal  = ~legal;
    assign ALUSrc   = is_i | is_lw | is_sw;
    assign ALUCtrl  = ALUCTRL_W'(alu_code);
    assign MemToReg = is_lw;
    // funct3[0] distinguishes bne from beq, so it inverts the zero test.
    assign PCSrc    = is_br & (Zero ^ funct3[0]);

    // Strobes are forced low during reset so an aborted instruction has no effect.
    assign MemRead  = ~rst & (state_q == S_MEM) & is_lw;
    assign MemWrite = ~rst & (state_q == S_MEM) & is_sw;
    assign RegWrite = ~rst & (state_q == S_WB) & (is_r | is_i | is_lw);
    assign loadPC   = ~rst & (state_q == S_WB);

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed scenarios followed by randomized instruction streams, checked
// against a table of supported RV32I encodings and a cycle-count model of
// the five-step instruction sequence.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;

    multicycle_ctrl #(.ALUCTRL_W(4), .STATE_W(3)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         f7_any;
        logic [3:0] alu;
        int         cls;
    } ent_t;

    ent_t        tbl[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          st_m;          // instruction step: 0..4 = IF..WB
    logic [31:0] cur_instr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (instr %08h step %0d)", tag, act, exp, cur_instr, st_m);
        end
    endtask

    task automatic add_ent(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input bit f7_any, input logic [3:0] alu, input int cls);
        ent_t e;
        e.op = op; e.f3 = f3; e.f7 = f7; e.f7_any = f7_any; e.alu = alu; e.cls = cls;
        tbl.push_back(e);
    endtask

    function automatic int find_ent(input logic [31:0] ins);
        foreach (tbl[i]) begin
            if (tbl[i].op == ins[6:0] && tbl[i].f3 == ins[14:12] &&
                (tbl[i].f7_any || tbl[i].f7 == ins[31:25]))
                return i;
        end
        return -1;
    endfunction

    // One clock: apply inputs after the falling edge, check, then advance the model.
    task automatic step(input logic rst_v, input logic zero_v);
        int   idx;
        int   cls;
        logic found;
        logic [3:0] e_alu;
        @(negedge clk);
        rst   = rst_v;
        Zero  = zero_v;
        instr = cur_instr;
        #1;
        idx   = find_ent(cur_instr);
        found = (idx >= 0);
        cls   = found ? tbl[idx].cls : -1;
        e_alu = found ? tbl[idx].alu : 4'b0010;
        check_eq("state",    32'(state),    32'(st_m));
        check_eq("illegal",  32'(illegal),  32'(!found));
        check_eq("ALUSrc",   32'(ALUSrc),   32'(cls == C_I || cls == C_LW || cls == C_SW));
        check_eq("ALUCtrl",  32'(ALUCtrl),  32'(e_alu));
        check_eq("MemToReg", 32'(MemToReg), 32'(cls == C_LW));
        check_eq("RegWrite", 32'(RegWrite), 32'(!rst_v && st_m == 4 && (cls == C_R || cls == C_I || cls == C_LW)));
        check_eq("MemRead",  32'(MemRead),  32'(!rst_v && st_m == 3 && cls == C_LW));
        check_eq("MemWrite", 32'(MemWrite), 32'(!rst_v && st_m == 3 && cls == C_SW));
        check_eq("loadPC",   32'(loadPC),   32'(!rst_v && st_m == 4));
        if (st_m == 4)
            check_eq("PCSrc", 32'(PCSrc), 32'(cls == C_BR && (zero_v ^ cur_instr[12])));
        @(posedge clk);
        st_m = rst_v ? 0 : (st_m + 1) % 5;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic zero_v);
        cur_instr = ins;
        repeat (5) step(1'b0, zero_v);
    endtask

    initial begin
        // R-type
        add_ent(7'b0110011, 3'b000, 7'h00, 0, 4'b0010, C_R);
        add_ent(7'b0110011, 3'b000, 7'h20, 0, 4'b0110, C_R);
        add_ent(7'b0110011, 3'b001, 7'h00, 0, 4'b1001, C_R);
        add_ent(7'b0110011, 3'b010, 7'h00, 0, 4'b0111, C_R);
        add_ent(7'b0110011, 3'b011, 7'h00, 0, 4'b1011, C_R);
        add_ent(7'b0110011, 3'b100, 7'h00, 0, 4'b1100, C_R);
        add_ent(7'b0110011, 3'b101, 7'h00, 0, 4'b1000, C_R);
        add_ent(7'b0110011, 3'b101, 7'h20, 0, 4'b1010, C_R);
        add_ent(7'b0110011, 3'b110, 7'h00, 0, 4'b0001, C_R);
        add_ent(7'b0110011, 3'b111, 7'h00, 0, 4'b0000, C_R);
        // I-ALU
        add_ent(7'b0010011, 3'b000, 7'h00, 1, 4'b0010, C_I);
        add_ent(7'b0010011, 3'b010, 7'h00, 1, 4'b0111, C_I);
        add_ent(7'b0010011, 3'b011, 7'h00, 1, 4'b1011, C_I);
        add_ent(7'b0010011, 3'b100, 7'h00, 1, 4'b1100, C_I);
        add_ent(7'b0010011, 3'b110, 7'h00, 1, 4'b0001, C_I);
        add_ent(7'b0010011, 3'b111, 7'h00, 1, 4'b0000, C_I);
        add_ent(7'b0010011, 3'b001, 7'h00, 0, 4'b1001, C_I);
        add_ent(7'b0010011, 3'b101, 7'h00, 0, 4'b1000, C_I);
        add_ent(7'b0010011, 3'b101, 7'h20, 0, 4'b1010, C_I);
        // memory and branches
        add_ent(7'b0000011, 3'b010, 7'h00, 1, 4'b0010, C_LW);
        add_ent(7'b0100011, 3'b010, 7'h00, 1, 4'b0010, C_SW);
        add_ent(7'b1100011, 3'b000, 7'h00, 1, 4'b0110, C_BR);
        add_ent(7'b1100011, 3'b001, 7'h00, 1, 4'b0110, C_BR);

        rst = 1'b1; Zero = 1'b0; instr = 32'h0; cur_instr = 32'h0;
        repeat (2) @(posedge clk);
        st_m = 0;

        // reset held for two cycles while a store sits in MEM, then a clean run
        cur_instr = 32'h0020A223;
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);

        run_instr(32'h002081B3, 1'b0);  // add
        run_instr(32'h402081B3, 1'b1);  // sub
        run_instr(32'h0080A283, 1'b0);  // lw
        run_instr(32'h0020A223, 1'b0);  // sw
        run_instr(32'h00208463, 1'b1);  // beq taken
        run_instr(32'h00208463, 1'b0);  // beq not taken
        run_instr(32'h00209463, 1'b0);  // bne taken
        run_instr(32'h00209463, 1'b1);  // bne not taken
        run_instr(32'hFFFFFFFF, 1'b1);  // illegal
        run_instr(32'h4020D193, 1'b0);  // srai
        run_instr(32'h40209193, 1'b0);  // slli with bit 30 set: illegal

        for (int n = 0; n < 2000; n++) begin
            if (st_m == 0) begin
                ent_t        e;
                logic [31:0] ins;
                int          r;
                e   = tbl[$urandom_range(tbl.size() - 1)];
                ins = $urandom;
                ins[6:0]   = e.op;
                ins[14:12] = e.f3;
                if (!e.f7_any) ins[31:25] = e.f7;
                r = $urandom_range(7);
                if (r == 0)      ins = $urandom;
                else if (r == 1) ins[25 + $urandom_range(6)] = ~ins[25 + $urandom_range(6)];
                else if (r == 2) ins[12 + $urandom_range(2)] = ~ins[12 + $urandom_range(2)];
                else if (r == 3) ins[$urandom_range(6)] = ~ins[$urandom_range(6)];
                cur_instr = ins;
            end
            step(($urandom_range(39) == 0), 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
